// File: rtl/uart_pkg.sv
// Shared UART line constants and transmitter state encoding.
// The receive path imports the same line-level constants.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous first-word fall-through FIFO feeding the UART transmitter.
// A write into a full FIFO is still accepted when a read happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_do;
  logic             rd_do;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_do = rd_en & ~empty;
  assign wr_do = wr_en & (~full | rd_do);
  assign dout  = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_do) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_do) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_do, rd_do})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes queue in a FIFO and leave as 8N1 frames,
// optionally with an even-parity bit, back to back with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 overflow,
  output logic                 tx_data,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic DONE_ON_ENTRY   = (CLKS_PER_BIT == 1);
  localparam logic MULTI_CYCLE     = (CLKS_PER_BIT > 1);

  tx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 pop;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign bit_end = (timer == T_LAST);
  assign busy    = (state != IDLE) | (fifo_count != '0);

  // Pop when idle, or on the final stop-bit cycle so the next start bit follows directly.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == STOP && bit_end) begin
        pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      sh       <= '0;
      tx_data  <= LINE_IDLE;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          timer   <= '0;
          tx_data <= LINE_IDLE;
          if (pop) begin
            sh      <= fifo_dout;
            state   <= START;
            tx_data <= START_BIT;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            idx     <= '0;
            state   <= DATA;
            tx_data <= sh[0];
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (idx == I_LAST) begin
              if (PARITY_EN != 0) begin
                state   <= PARITY;
                tx_data <= ^sh;
              end else begin
                state   <= STOP;
                tx_data <= STOP_BIT;
                tx_done <= DONE_ON_ENTRY;
              end
            end else begin
              idx     <= idx + IW'(1);
              tx_data <= sh[idx + IW'(1)];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            timer   <= '0;
            state   <= STOP;
            tx_data <= STOP_BIT;
            tx_done <= DONE_ON_ENTRY;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (pop) begin
              sh      <= fifo_dout;
              state   <= START;
              tx_data <= START_BIT;
            end else begin
              state   <= IDLE;
              tx_data <= LINE_IDLE;
            end
          end else begin
            timer   <= timer + TW'(1);
            // Registered pulse must land in the last stop cycle, so raise it one cycle early.
            tx_done <= MULTI_CYCLE && (timer == T_PRE);
          end
        end
        default: begin
          state   <= IDLE;
          tx_data <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: two instances (4 clk/bit no parity,
// 1 clk/bit with parity); line monitors decode frames and compare against queued bytes.
module tb_uart_tx_buffered;

  localparam int CA = 4;
  localparam int CB = 1;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [7:0] din_a = '0;
  logic [7:0] din_b = '0;
  logic       wr_a = 1'b0;
  logic       wr_b = 1'b0;
  logic       full_a, ovf_a, tx_a, busy_a, done_a;
  logic       full_b, ovf_b, tx_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         done_q[$];
  int         gcyc = 0;

  bit         mact[2];
  int         mcyc[2];
  logic [7:0] mbyte[2];
  logic       mstop[2];
  logic       mpar[2];
  int         nframes[2];

  uart_tx_buffered #(.CLKS_PER_BIT(CA), .FIFO_DEPTH(4), .PARITY_EN(0)) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .wr_en(wr_a), .full(full_a),
    .overflow(ovf_a), .tx_data(tx_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(CB), .FIFO_DEPTH(4), .PARITY_EN(1)) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .wr_en(wr_b), .full(full_b),
    .overflow(ovf_b), .tx_data(tx_b), .busy(busy_b), .tx_done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  always @(negedge clk) begin
    if (!rst_a && done_a === 1'b1) done_q.push_back(gcyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic [7:0] qpop(input int id);
    if (id == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  // Decode one line sample per cycle; sample bits mid-period, score the frame on its last cycle.
  task automatic mon_step(input int id, input logic rv, input logic tx, input logic dn,
                          input logic bs, input int cpb, input int par);
    int last;
    int k;
    logic [7:0] e;
    string s;
    s = (id == 0) ? "a" : "b";
    if (rv) begin
      mact[id] = 1'b0;
      return;
    end
    last = (10 + par) * cpb - 1;
    if (!mact[id] && tx === 1'b0) begin
      mact[id]  = 1'b1;
      mcyc[id]  = 0;
      mbyte[id] = '0;
    end
    check({"busy_", s}, bs, mact[id] || qsize(id) != 0);
    check({"tx_done_", s}, dn, mact[id] && mcyc[id] == last);
    if (!mact[id]) return;
    if (mcyc[id] % cpb == cpb / 2) begin
      k = mcyc[id] / cpb;
      if (k == 0) check({"start_bit_", s}, tx, 0);
      else if (k <= 8) mbyte[id][k-1] = tx;
      else if (par != 0 && k == 9) mpar[id] = tx;
      else mstop[id] = tx;
    end
    if (mcyc[id] == last) begin
      check({"frame_expected_", s}, qsize(id) != 0, 1);
      if (qsize(id) != 0) begin
        e = qpop(id);
        check({"byte_", s}, mbyte[id], e);
        if (par != 0) check({"parity_", s}, mpar[id], ^e);
      end
      check({"stop_bit_", s}, mstop[id], 1);
      nframes[id]++;
      mact[id] = 1'b0;
    end else begin
      mcyc[id]++;
    end
  endtask

  always @(negedge clk) mon_step(0, rst_a, tx_a, done_a, busy_a, CA, 0);
  always @(negedge clk) mon_step(1, rst_b, tx_b, done_b, busy_b, CB, 1);

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] b, input bit accept);
    din_a = b;
    wr_a  = 1'b1;
    if (accept) qa.push_back(b);
    tick();
  endtask

  task automatic drain_a(input string name);
    for (int i = 0; i < 600 && qa.size() != 0; i++) tick();
    check(name, qa.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    int f0;
    int seq_b[11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    logic [7:0] burst[6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    logic exp_full[6] = '{0, 0, 0, 0, 1, 1};
    logic exp_ovf[6]  = '{0, 0, 0, 0, 0, 1};

    // Reset values
    tick();
    tick();
    check("rst_tx", tx_a, 1);
    check("rst_full", full_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    rst_a = 1'b0;
    tick();

    // Single byte 0x55 and first-byte latency
    write_a(8'h55, 1);
    wr_a = 1'b0;
    check("lat_tx_after_write", tx_a, 1);
    check("lat_busy_after_write", busy_a, 1);
    tick();
    check("lat_start_bit", tx_a, 0);
    drain_a("drain_single");

    // Parity frame 0xA3 on the 1 clk/bit instance
    rst_b = 1'b0;
    tick();
    din_b = 8'hA3;
    wr_b  = 1'b1;
    qb.push_back(8'hA3);
    tick();
    wr_b = 1'b0;
    check("par_idle_after_write", tx_b, 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("par_seq", tx_b, seq_b[i]);
    end
    tick();
    check("par_back_idle", tx_b, 1);
    check("par_queue_empty", qb.size(), 0);

    // Back-to-back frames with tx_done spacing
    done_q.delete();
    write_a(8'h01, 1);
    write_a(8'h02, 1);
    write_a(8'h03, 1);
    wr_a = 1'b0;
    drain_a("drain_b2b");
    check("b2b_done_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      check("b2b_gap1", done_q[1] - done_q[0], 10 * CA);
      check("b2b_gap2", done_q[2] - done_q[1], 10 * CA);
    end

    // Overflow: six writes, sixth dropped
    f0 = nframes[0];
    for (int i = 0; i < 6; i++) begin
      write_a(burst[i], i < 5);
      check("ovf_full", full_a, exp_full[i]);
      check("ovf_flag", ovf_a, exp_ovf[i]);
    end
    wr_a = 1'b0;
    drain_a("drain_ovf");
    check("ovf_frames", nframes[0] - f0, 5);
    check("ovf_sticky", ovf_a, 1);
    check("ovf_full_after", full_a, 0);

    // Reset during data bit 3 with two bytes queued
    f0 = nframes[0];
    write_a(8'hC1, 1);
    write_a(8'hC2, 1);
    write_a(8'hC3, 1);
    wr_a = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst_a = 1'b1;
    qa.delete();
    tick();
    check("mid_rst_tx", tx_a, 1);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_full", full_a, 0);
    check("mid_rst_ovf", ovf_a, 0);
    rst_a = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("mid_rst_no_frames", nframes[0] - f0, 0);

    // Full FIFO plus write on the STOP->START pop cycle
    write_a(8'hD1, 1);
    write_a(8'hD2, 1);
    write_a(8'hD3, 1);
    write_a(8'hD4, 1);
    write_a(8'hD5, 1);
    wr_a = 1'b0;
    for (int i = 0; i < 36; i++) tick();
    check("fp_done_before_pop", done_a, 1);
    check("fp_full_before_pop", full_a, 1);
    write_a(8'hD6, 1);
    wr_a = 1'b0;
    check("fp_full_after_pop", full_a, 1);
    check("fp_ovf", ovf_a, 0);
    check("fp_next_start", tx_a, 0);
    drain_a("drain_full_pop");
    check("fp_ovf_end", ovf_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
